// File: rtl/spi_eeprom_pkg.sv
// rtl/spi_eeprom_pkg.sv - shared opcodes and FSM states for the SPI EEPROM responder
// Contents: EEPROM opcode constants and the responder state encoding.
package spi_eeprom_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RDATA,
    WDATA,
    STATUS,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - 2-flop synchronizers and edge detect for SPI pins
// Ports:
//   clk, nreset          system clock, async active-low reset
//   cs, sclk, mosi       raw pins, asynchronous to clk
//   cs_s, mosi_s         synchronized chip select and data
//   sclk_rise/sclk_fall  one-clk pulses on synchronized SCLK edges
//   cs_rise/cs_fall      one-clk pulses on synchronized CS edges
module spi_pin_sync (
  input  logic clk,
  input  logic nreset,
  input  logic cs,
  input  logic sclk,
  input  logic mosi,
  output logic cs_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall
);

  logic [1:0] cs_sync;
  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic       cs_prev;
  logic       sclk_prev;

  // CS resets to the deasserted level so release from reset is not seen as a select.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_prev   <= cs_sync[1];
      sclk_prev <= sclk_sync[1];
    end
  end

  // MOSI has the same synchronizer depth as SCLK, so it lines up with sclk_rise.
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise =  sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] &  sclk_prev;
  assign cs_rise   =  cs_sync[1] & ~cs_prev;
  assign cs_fall   = ~cs_sync[1] &  cs_prev;

endmodule

// File: rtl/spi_eeprom_responder.sv
// rtl/spi_eeprom_responder.sv - SPI mode-0 slave emulating a small serial EEPROM
// Ports:
//   clk, nreset     system clock, async active-low reset
//   eeprom_cs       chip select (active low), async
//   eeprom_clk      SCLK from master, async
//   eeprom_in       MOSI
//   eeprom_out      MISO
//   eeprom_out_oe   MISO drive enable, high during READ/RDSR data phases
//   busy            synchronized, inverted chip select
module spi_eeprom_responder
  import spi_eeprom_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int ADDR_BYTES = 3
) (
  input  logic clk,
  input  logic nreset,
  input  logic eeprom_cs,
  input  logic eeprom_clk,
  input  logic eeprom_in,
  output logic eeprom_out,
  output logic eeprom_out_oe,
  output logic busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ABITS = ADDR_BYTES * 8;
  localparam int CW    = $clog2(ABITS + 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s, cs_s;

  spi_pin_sync u_pin_sync (
    .clk       (clk),
    .nreset    (nreset),
    .cs        (eeprom_cs),
    .sclk      (eeprom_clk),
    .mosi      (eeprom_in),
    .cs_s      (cs_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall)
  );

  assign busy = ~cs_s;

  state_t          state;
  logic            wel;
  logic            is_write;
  logic [CW-1:0]   bit_cnt;
  logic [7:0]      shift_in;
  logic [7:0]      out_sr;
  logic [AW-1:0]   addr;
  logic [7:0]      mem [DEPTH];

  logic [7:0]      rx_byte;
  logic [AW-1:0]   next_addr;
  logic [AW-1:0]   addr_inc;
  logic [7:0]      status_byte;

  assign rx_byte     = {shift_in[6:0], mosi_s};
  // Shifting into an AW-bit register keeps only the low address bits.
  assign next_addr   = {addr[AW-2:0], mosi_s};
  assign addr_inc    = addr + 1'b1;
  assign status_byte = {6'b0, wel, 1'b0};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      wel           <= 1'b0;
      is_write      <= 1'b0;
      bit_cnt       <= '0;
      shift_in      <= '0;
      out_sr        <= '0;
      addr          <= '0;
      eeprom_out    <= 1'b0;
      eeprom_out_oe <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
    end else if (cs_rise) begin
      // Abort wins over any simultaneous SCLK edge; partial bytes are dropped.
      state         <= IDLE;
      bit_cnt       <= '0;
      eeprom_out    <= 1'b0;
      eeprom_out_oe <= 1'b0;
      is_write      <= 1'b0;
      if (is_write) wel <= 1'b0;
    end else if (cs_fall) begin
      state    <= CMD;
      bit_cnt  <= '0;
      shift_in <= '0;
      is_write <= 1'b0;
    end else begin
      case (state)
        CMD: if (sclk_rise) begin
          shift_in <= rx_byte;
          if (bit_cnt == CW'(7)) begin
            bit_cnt <= '0;
            case (rx_byte)
              OP_READ:  state <= ADDR;
              OP_WRITE: begin
                if (wel) begin
                  state    <= ADDR;
                  is_write <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end
              OP_WREN: begin
                wel   <= 1'b1;
                state <= IGNORE;
              end
              OP_WRDI: begin
                wel   <= 1'b0;
                state <= IGNORE;
              end
              OP_RDSR: begin
                state         <= STATUS;
                out_sr        <= status_byte;
                eeprom_out    <= status_byte[7];
                eeprom_out_oe <= 1'b1;
              end
              default: state <= IGNORE;
            endcase
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ADDR: if (sclk_rise) begin
          addr <= next_addr;
          if (bit_cnt == CW'(ABITS - 1)) begin
            bit_cnt <= '0;
            if (is_write) begin
              state <= WDATA;
            end else begin
              // First byte is presented before the next SCLK rise.
              state         <= RDATA;
              out_sr        <= mem[next_addr];
              eeprom_out    <= mem[next_addr][7];
              eeprom_out_oe <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        WDATA: if (sclk_rise) begin
          shift_in <= rx_byte;
          if (bit_cnt == CW'(7)) begin
            mem[addr] <= rx_byte;
            addr      <= addr_inc;
            bit_cnt   <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        // bit_cnt counts rises within the byte. The fall right after a load
        // (bit_cnt==0) must not shift, since the MSB has not been sampled yet.
        RDATA, STATUS: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
          end else if (sclk_fall) begin
            if (bit_cnt == CW'(8)) begin
              bit_cnt <= '0;
              if (state == RDATA) begin
                out_sr     <= mem[addr_inc];
                eeprom_out <= mem[addr_inc][7];
                addr       <= addr_inc;
              end else begin
                out_sr     <= status_byte;
                eeprom_out <= status_byte[7];
              end
            end else if (bit_cnt != '0) begin
              out_sr     <= {out_sr[6:0], 1'b0};
              eeprom_out <= out_sr[6];
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// tb/tb_spi_eeprom_responder.sv - self-checking bench for spi_eeprom_responder
module tb_spi_eeprom_responder;

  localparam int DEPTH = 128;
  localparam int HALF  = 6;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic cs = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic miso, oe, busy;

  spi_eeprom_responder #(.DEPTH(DEPTH), .ADDR_BYTES(3)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .eeprom_cs     (cs),
    .eeprom_clk    (sclk),
    .eeprom_in     (mosi),
    .eeprom_out    (miso),
    .eeprom_out_oe (oe),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] model_mem [DEPTH];
  logic       model_wel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'(i);
    model_wel = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      tick(HALF);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] tx);
    logic [7:0] rx;
    xfer_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    tick(HALF);
    check("busy_on", busy, 1'b1);
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    cs = 1'b1;
    tick(3);
    check("oe_off", oe, 1'b0);
    check("out_off", miso, 1'b0);
    check("busy_off", busy, 1'b0);
    tick(HALF);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    send_byte(op);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0] rx;
    cs_begin();
    send_hdr(8'h03, a);
    for (int i = 0; i < n; i++) begin
      xfer_bits(8'h00, 8, rx);
      check("read", rx, model_mem[(int'(a) + i) % DEPTH]);
      check("read_oe", oe, 1'b1);
    end
    cs_end();
  endtask

  task automatic do_write(input logic [23:0] a, input byte_q_t data);
    cs_begin();
    send_hdr(8'h02, a);
    foreach (data[i]) send_byte(data[i]);
    cs_end();
    if (model_wel)
      foreach (data[i]) model_mem[(int'(a) + i) % DEPTH] = data[i];
    model_wel = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] op);
    cs_begin();
    send_byte(op);
    cs_end();
    if (op == 8'h06) model_wel = 1'b1;
    if (op == 8'h04) model_wel = 1'b0;
  endtask

  task automatic do_rdsr(input int n);
    logic [7:0] rx;
    cs_begin();
    send_byte(8'h05);
    for (int i = 0; i < n; i++) begin
      xfer_bits(8'h00, 8, rx);
      check("rdsr", rx, {6'b0, model_wel, 1'b0});
    end
    check("rdsr_oe", oe, 1'b1);
    cs_end();
  endtask

  initial begin
    logic [7:0] rx;
    byte_q_t q;
    model_reset();

    tick(3);
    check("rst_out", miso, 1'b0);
    check("rst_oe", oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    nreset = 1'b1;
    tick(4);
    check("idle_busy", busy, 1'b0);

    // Sequential read of the reset pattern.
    do_read(24'h000000, 100);

    // Enabled write then readback; WEL clears afterwards.
    do_op(8'h06);
    q = '{8'hA5, 8'h5A};
    do_write(24'h000010, q);
    do_read(24'h000010, 3);
    check("wr_a5", model_mem[8'h10], 8'hA5);
    do_rdsr(1);

    // Write without WEL is ignored.
    q = '{8'hFF};
    do_write(24'h000020, q);
    do_read(24'h000020, 1);
    do_rdsr(1);
    do_op(8'h06);
    do_rdsr(2);
    do_op(8'h04);
    do_rdsr(1);

    // Wrap and ignored upper address bits.
    do_read(24'h00007E, 4);
    do_read(24'h000105, 1);

    // Unknown opcode keeps MISO undriven.
    cs_begin();
    send_byte(8'h9F);
    xfer_bits(8'h00, 8, rx);
    check("unk_oe", oe, 1'b0);
    check("unk_rx", rx, 8'h00);
    cs_end();

    // Partial byte at CS rise is discarded and WEL still clears.
    do_op(8'h06);
    cs_begin();
    send_hdr(8'h02, 24'h000030);
    xfer_bits(8'hFF, 5, rx);
    cs_end();
    model_wel = 1'b0;
    do_read(24'h000030, 1);
    do_rdsr(1);

    // Reset in the middle of a read.
    do_op(8'h06);
    q = '{8'h11};
    do_write(24'h000000, q);
    cs_begin();
    send_hdr(8'h03, 24'h000000);
    send_byte(8'h00);
    xfer_bits(8'h00, 4, rx);
    nreset = 1'b0;
    #1;
    check("mid_rst_out", miso, 1'b0);
    check("mid_rst_oe", oe, 1'b0);
    cs = 1'b1;
    tick(3);
    nreset = 1'b1;
    model_reset();
    tick(HALF);
    do_read(24'h000000, 2);

    // Randomized transactions against the model.
    for (int t = 0; t < 25; t++) begin
      int kind;
      int n;
      logic [23:0] a;
      kind = $urandom_range(0, 4);
      a = 24'($urandom);
      n = $urandom_range(1, 5);
      case (kind)
        0: do_read(a, n);
        1: begin
          q = {};
          for (int i = 0; i < n; i++) q.push_back(8'($urandom));
          do_write(a, q);
        end
        2: do_op(8'h06);
        3: do_op(8'h04);
        default: do_rdsr(n);
      endcase
    end
    do_read(24'h000000, DEPTH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
